mux_rr_arb: RTL and testbench

- Parametrised N-channel successor to the team's 2:1 select mux.
- Merges NCH valid/ready input streams of WIDTH bits onto one registered output stream.
- Arbitration is fixed-priority or round-robin, chosen at run time.
- Sits between multiple producers and a single consumer. It registers the winning beat and reports the source channel index alongside it.

---
 rtl/mux_rr_arb.sv | 107 ++++++++++
 tb/tb_mux_rr_arb.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arb.sv
// N-channel valid/ready merge onto one registered output stream.
// Arbitration is fixed-priority (mode=0) or round-robin from ptr (mode=1).
module mux_rr_arb #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready
);

    logic                 out_valid_r;
    logic [WIDTH-1:0]     out_data_r;
    logic [SEL_W-1:0]     out_sel_r;
    logic [SEL_W-1:0]     ptr_r;
    logic [SEL_W-1:0]     grant_idx_s;
    logic [SEL_W-1:0]     cand_idx_s;
    logic                 grant_found_s;
    logic                 hit_s;
    logic                 can_load_s;
    logic                 load_s;
    logic [NCH-1:0]       grant_onehot_s;
    logic [NCH-1:0]       in_ready_s;

    // Channel index reached by stepping off positions forward from base, modulo NCH.
    function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] base,
                                                  input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(NCH)) begin
            sum = sum - 32'(NCH);
        end else begin
            sum = sum;
        end
        return sum[SEL_W-1:0];
    endfunction

    // Grant search: first valid channel in priority order (ptr-relative in round-robin).
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_idx_s    = '0;
        hit_s         = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            cand_idx_s    = mode ? rr_index(ptr_r, k) : k[SEL_W-1:0];
            hit_s         = !grant_found_s && in_valid[cand_idx_s];
            grant_idx_s   = hit_s ? cand_idx_s : grant_idx_s;
            grant_found_s = grant_found_s || hit_s;
        end
    end

    assign can_load_s     = !out_valid_r || out_ready;
    assign load_s         = can_load_s && grant_found_s;
    assign grant_onehot_s = {{(NCH-1){1'b0}}, 1'b1} << grant_idx_s;

    // Producer accept: only the loading channel, and never while reset is held.
    always_comb begin
        in_ready_s = '0;
        if (load_s && rst_n) begin
            in_ready_s = grant_onehot_s;
        end else begin
            in_ready_s = '0;
        end
    end

    // Output register: load replaces the entry, otherwise drain or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sel_r   <= '0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= in_data[32'(grant_idx_s)*WIDTH +: WIDTH];
            out_sel_r   <= grant_idx_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Round-robin pointer moves past the winner only on round-robin loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (load_s && mode) begin
            if (grant_idx_s == SEL_W'(NCH - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= grant_idx_s + 1'b1;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Self-checking bench for mux_rr_arb: directed scenarios, then random traffic
// compared against a behavioural arbiter model.
module tb_mux_rr_arb;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 mode;
    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_sel;
    logic                 out_ready;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit              m_valid;
    logic [WIDTH-1:0] m_data;
    int              m_sel;
    int              m_ptr;

    mux_rr_arb #(.WIDTH(WIDTH), .NCH(NCH), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [NCH-1:0] v, input logic md, input int ptr);
        int i;
        for (int k = 0; k < NCH; k++) begin
            i = md ? (ptr + k) % NCH : k;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        m_ptr   = 0;
    endtask

    task automatic set_lane(input int i, input logic [WIDTH-1:0] d);
        in_data[i*WIDTH +: WIDTH] = d;
    endtask

    // One clock: check in_ready before the edge, advance model, check outputs after.
    task automatic cycle(input string tag);
        int g;
        bit can_load;
        logic [NCH-1:0] exp_rdy;
        #1;
        can_load = !m_valid || out_ready;
        g = pick(in_valid, mode, m_ptr);
        exp_rdy = (can_load && g >= 0) ? (4'b0001 << g) : 4'b0000;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (can_load && g >= 0) begin
            m_data  = in_data[g*WIDTH +: WIDTH];
            m_sel   = g;
            m_valid = 1'b1;
            if (mode) m_ptr = (g + 1) % NCH;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".out_data"},  32'(out_data),  32'(m_data));
        check({tag, ".out_sel"},   32'(out_sel),   32'(m_sel));
    endtask

    initial begin
        // Reset with every channel requesting
        rst_n = 1'b0; mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < NCH; i++) set_lane(i, 8'(8'h50 + i));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_data",  32'(out_data),  32'd0);
        check("rst.out_sel",   32'(out_sel),   32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd0);
        rst_n = 1'b1;
        cycle("rst_first");
        check("rst_first.sel",  32'(out_sel),  32'd0);
        check("rst_first.data", 32'(out_data), 32'h50);

        // Fixed priority with X on idle lanes
        in_valid = 4'b1010;
        in_data  = {8'h33, 8'hxx, 8'h11, 8'hxx};
        for (int k = 0; k < 3; k++) begin
            cycle("fixed");
            check("fixed.data", 32'(out_data), 32'h11);
            check("fixed.sel",  32'(out_sel),  32'd1);
        end

        // Round-robin fairness
        mode = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < NCH; i++) set_lane(i, 8'(8'hA0 + i));
        for (int k = 0; k < 8; k++) begin
            cycle("rr");
            check("rr.valid", 32'(out_valid), 32'd1);
            check("rr.sel",   32'(out_sel),   32'(k % 4));
            check("rr.data",  32'(out_data),  32'(8'hA0 + k % 4));
        end

        // Backpressure: ch0 loaded, then stalled, then ch2 follows
        in_valid = 4'b0101;
        cycle("bp_load");
        check("bp_load.sel", 32'(out_sel), 32'd0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle("bp_stall");
            check("bp_stall.in_ready", 32'(in_ready), 32'd0);
            check("bp_stall.sel",  32'(out_sel),  32'd0);
            check("bp_stall.data", 32'(out_data), 32'hA0);
        end
        out_ready = 1'b1;
        cycle("bp_release");
        check("bp_release.sel",  32'(out_sel),  32'd2);
        check("bp_release.data", 32'(out_data), 32'hA2);

        // Wrap from ptr=3 to channel 0, then drain
        in_valid = 4'b1001;
        cycle("wrap3");
        check("wrap3.sel", 32'(out_sel), 32'd3);
        cycle("wrap0");
        check("wrap0.sel", 32'(out_sel), 32'd0);
        in_valid = 4'b0000;
        cycle("drain");
        check("drain.valid", 32'(out_valid), 32'd0);
        check("drain.sel",   32'(out_sel),   32'd0);

        // Async reset between edges with a held beat
        in_valid = 4'b0100; out_ready = 1'b0;
        cycle("pre_arst");
        check("pre_arst.valid", 32'(out_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.in_ready",  32'(in_ready),  32'd0);
        check("arst.out_sel",   32'(out_sel),   32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        in_valid = 4'b1111;
        cycle("post_arst");
        check("post_arst.sel", 32'(out_sel), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            mode      = 1'($urandom_range(0, 1));
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NCH; i++) begin
                if (in_valid[i]) set_lane(i, 8'($urandom));
                else             set_lane(i, 8'hxx);
            end
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
